stream_block_multiplier: RTL and testbench

// - Block-serial big-integer multiplier: accepts two BITS_IN_NUM-bit operands streamed one

---
 rtl/mult_pkg.sv | 11 +
 rtl/evt_counter.sv | 20 ++
 rtl/stream_block_multiplier.sv | 157 +++++++++++++++
 tb/tb_stream_block_multiplier.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the block-serial multiplier.
package mult_pkg;

    typedef enum logic {LOAD, COMPUTE} state_t;

    // Column sums of up to n W x W products plus the incoming carry fit in this width.
    function automatic int unsigned acc_width(int unsigned w, int unsigned n);
        return 2 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/evt_counter.sv
// Wrapping event counter: counts evt_in pulses modulo MAX_COUNT.
module evt_counter #(
    parameter int unsigned MAX_COUNT = 4,
    localparam int unsigned COUNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               evt_in,
    output logic [COUNT_W-1:0] count_out
);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (evt_in) begin
            count_out <= (count_out == COUNT_W'(MAX_COUNT - 1)) ? '0 : count_out + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/stream_block_multiplier.sv
// Block-serial big-integer multiplier: streams in two N-block operands, product-scans
// one MAC per cycle and streams out the 2N-block product LSB first.
module stream_block_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] n_in,
    input  logic [REGISTER_SIZE-1:0] m_in,
    input  logic                     valid_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    output logic                     final_out,
    output logic                     ready_out
);

    localparam int unsigned W     = REGISTER_SIZE;
    localparam int unsigned N     = BITS_IN_NUM / REGISTER_SIZE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned COL_W = $clog2(2 * N);
    localparam int unsigned ACC_W = acc_width(W, N);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(2 * N - 2);
    localparam logic [COL_W-1:0] FINAL_COL = COL_W'(2 * N - 1);
    localparam logic [COL_W-1:0] TOP_BLK   = COL_W'(N - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_mem [N];
    logic [W-1:0]       b_mem [N];
    logic [IDX_W-1:0]   in_idx;
    logic [COL_W-1:0]   out_col;
    logic [COL_W-1:0]   k_q, k_d, i_q, i_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [W-1:0]       data_d;
    logic               valid_d, final_d;
    logic               accept, last_in, term_live;
    logic [IDX_W-1:0]   a_idx, b_idx;
    logic [W-1:0]       a_op, b_op;
    logic [2*W-1:0]     prod;

    function automatic logic [COL_W-1:0] i_lo(logic [COL_W-1:0] k);
        return (k > TOP_BLK) ? k - TOP_BLK : '0;
    endfunction

    function automatic logic [COL_W-1:0] i_hi(logic [COL_W-1:0] k);
        return (k > TOP_BLK) ? TOP_BLK : k;
    endfunction

    assign accept    = (state_q == LOAD) && valid_in;
    assign last_in   = accept && (in_idx == IDX_W'(N - 1));
    assign term_live = (k_q <= LAST_COL);
    assign ready_out = (state_q == LOAD);

    evt_counter #(.MAX_COUNT(N)) u_in_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .evt_in    (accept),
        .count_out (in_idx)
    );

    evt_counter #(.MAX_COUNT(2 * N)) u_out_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .evt_in    (valid_d),
        .count_out (out_col)
    );

    always_ff @(posedge clk_in) begin
        if (accept) begin
            a_mem[in_idx] <= n_in;
            b_mem[in_idx] <= m_in;
        end
    end

    // The first term A[0]*B[0] is issued on the accepting edge; with a single block it
    // has to come straight from the input ports.
    assign a_idx = IDX_W'(i_q);
    assign b_idx = IDX_W'(k_q - i_q);
    assign a_op  = (N == 1 && state_q == LOAD) ? n_in : a_mem[a_idx];
    assign b_op  = (N == 1 && state_q == LOAD) ? m_in : b_mem[b_idx];
    assign prod  = a_op * b_op;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        acc_d   = acc_q;
        data_d  = data_out;
        valid_d = 1'b0;
        final_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (last_in) begin
                    state_d = COMPUTE;
                    acc_d   = ACC_W'(prod);
                    k_d     = COL_W'(1);
                    i_d     = '0;
                end
            end
            COMPUTE: begin
                if (term_live) begin
                    // First term of a column doubles as the hand-off of the previous one.
                    if (i_q == i_lo(k_q) && k_q != '0) begin
                        data_d  = acc_q[W-1:0];
                        valid_d = 1'b1;
                        acc_d   = (acc_q >> W) + ACC_W'(prod);
                    end else begin
                        acc_d = acc_q + ACC_W'(prod);
                    end
                    if (i_q == i_hi(k_q)) begin
                        k_d = k_q + COL_W'(1);
                        i_d = i_lo(k_q + COL_W'(1));
                    end else begin
                        i_d = i_q + COL_W'(1);
                    end
                end else begin
                    data_d  = acc_q[W-1:0];
                    valid_d = 1'b1;
                    if (out_col == FINAL_COL) begin
                        final_d = 1'b1;
                        acc_d   = '0;
                        k_d     = '0;
                        i_d     = '0;
                        state_d = LOAD;
                    end else begin
                        acc_d = acc_q >> W;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= LOAD;
            k_q       <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            final_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            i_q       <= i_d;
            acc_q     <= acc_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            final_out <= final_d;
        end
    end

endmodule

// File: tb/tb_stream_block_multiplier.sv
// Self-checking bench for stream_block_multiplier (W=32, B=128, N=4) against a
// wide-integer reference product.
module tb_stream_block_multiplier;

    localparam int W    = 32;
    localparam int BITS = 128;
    localparam int N    = BITS / W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  n_in = '0;
    logic [W-1:0]  m_in = '0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          final_out;
    logic          ready_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    stream_block_multiplier #(
        .REGISTER_SIZE (W),
        .BITS_IN_NUM   (BITS)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .n_in      (n_in),
        .m_in      (m_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .final_out (final_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*BITS-1:0] ref_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [2*BITS-1:0] ea;
        logic [2*BITS-1:0] eb;
        ea = {{BITS{1'b0}}, a};
        eb = {{BITS{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"}, data_out, '0);
        check({tag, " valid_out"}, W'(valid_out), '0);
        check({tag, " final_out"}, W'(final_out), '0);
        check({tag, " ready_out"}, W'(ready_out), W'(1));
    endtask

    // Drives one block per cycle starting now; returns the posedge count of the accepting edge.
    task automatic load(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input string tag,
                        output int acc_cyc);
        for (int j = 0; j < N; j++) begin
            check({tag, " ready before block"}, W'(ready_out), W'(1));
            n_in     = a[W*j +: W];
            m_in     = b[W*j +: W];
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic collect(input logic [2*BITS-1:0] exp, input int acc_cyc, input string tag,
                           input bit noise);
        int got;
        got = 0;
        for (int t = 0; t < 100 && got < 2 * N; t++) begin
            @(negedge clk);
            if (valid_out) begin
                check({tag, " data"}, data_out, exp[W*got +: W]);
                check({tag, " final flag"}, W'(final_out), W'(got == 2 * N - 1));
                if (got == 2 * N - 1)
                    check({tag, " latency"}, W'(cyc - acc_cyc), W'(N * N + 1));
                got++;
            end else begin
                check({tag, " stray final"}, W'(final_out), '0);
            end
            if (got < 2 * N) check({tag, " ready low"}, W'(ready_out), '0);
            if (noise && got < 2 * N) begin
                n_in     = $urandom;
                m_in     = $urandom;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        check({tag, " pulse count"}, W'(got), W'(2 * N));
    endtask

    task automatic quiet(input int cycles, input string tag);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            check({tag, " quiet valid"}, W'(valid_out), '0);
            check({tag, " quiet final"}, W'(final_out), '0);
        end
    endtask

    task automatic run_product(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                               input string tag, input bit noise);
        int acc_cyc;
        load(a, b, tag, acc_cyc);
        collect(ref_mul(a, b), acc_cyc, tag, noise);
        quiet(2, tag);
    endtask

    initial begin
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] ones;
        int acc_cyc;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Small operands, single-block carry, all-ones
        run_product(BITS'(3), BITS'(5), "small", 1'b0);
        run_product(BITS'(32'hFFFF_FFFF), BITS'(32'hFFFF_FFFF), "carry", 1'b0);
        ones = '1;
        run_product(ones, ones, "all_ones", 1'b0);

        // Random operands
        for (int r = 0; r < 3; r++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            run_product(a, b, "random", 1'b0);
        end

        // Backpressure: valid_in toggling with junk during COMPUTE
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        run_product(a, b, "backpressure", 1'b1);

        // Reset mid-compute, then a fresh load
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        load(a, b, "abort", acc_cyc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_product(BITS'(3), BITS'(5), "after_reset", 1'b0);

        // Back-to-back products
        load(BITS'(3), BITS'(5), "b2b_first", acc_cyc);
        collect(ref_mul(BITS'(3), BITS'(5)), acc_cyc, "b2b_first", 1'b0);
        load(BITS'(7), BITS'(9), "b2b_second", acc_cyc);
        collect(ref_mul(BITS'(7), BITS'(9)), acc_cyc, "b2b_second", 1'b0);
        quiet(2, "b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
